dmem_pipe: RTL

Parametrised, pipelined data memory for the MEM stage of the MIPS pipeline, successor to the single-cycle masked memory. It accepts one load or store per cycle under a ready/stall handshake. Byte-lane masks are generated internally from access size and address, and misaligned accesses are detected. Loads return sign- or zero-extended data after a configurable read latency.

---
 rtl/dmem_pipe.sv | 115 +++++++++++
 1 files changed

// File: rtl/dmem_pipe.sv
// rtl/dmem_pipe.sv - pipelined byte-maskable data memory for the MEM stage
// Internal lane masks, misalignment detection and load extension in the last stage.
module dmem_pipe #(
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 10,
  parameter int READ_LAT = 1
) (
  input  logic              m_clk,
  input  logic              m_rst,
  input  logic              m_i_req,
  input  logic              m_i_we,
  input  logic [AWIDTH-1:0] m_i_addr,
  input  logic [1:0]        m_i_size,
  input  logic              m_i_unsigned,
  input  logic [DWIDTH-1:0] m_i_store_data,
  input  logic              m_i_stall,
  output logic              m_o_ready,
  output logic              m_o_ack,
  output logic [DWIDTH-1:0] m_o_load_data,
  output logic              m_o_misaligned
);
  localparam int NB    = DWIDTH / 8;
  localparam int OB    = $clog2(NB);
  localparam int WORDS = 2 ** (AWIDTH - OB);

  typedef struct packed {
    logic              valid;
    logic              mis;
    logic              is_load;
    logic [1:0]        size;
    logic              uns;
    logic [OB-1:0]     off;
    logic [DWIDTH-1:0] data;
  } stage_t;

  logic [DWIDTH-1:0]      mem [WORDS];
  logic [OB-1:0]          off;
  logic [AWIDTH-OB-1:0]   widx;
  logic                   mis;
  logic                   accept;
  logic [NB-1:0]          mask;
  logic [DWIDTH-1:0]      wdata;
  stage_t                 st [READ_LAT];
  stage_t                 fin;
  logic [DWIDTH-1:0]      sh;
  logic [DWIDTH-1:0]      ext;
  logic                   sgn;
  int                     w;

  assign m_o_ready = ~m_i_stall & ~m_rst;
  assign accept    = m_i_req & m_o_ready;
  assign off       = m_i_addr[OB-1:0];
  assign widx      = m_i_addr[AWIDTH-1:OB];
  assign wdata     = m_i_store_data << {off, 3'b000};

  always_comb begin
    mis = 1'b0;
    case (m_i_size)
      2'd1:    mis = m_i_addr[0];
      2'd2:    mis = |m_i_addr[1:0];
      2'd3:    mis = (DWIDTH < 64) || (|m_i_addr[2:0]);
      default: mis = 1'b0;
    endcase
  end

  // Contiguous run of 2^size lanes starting at the byte offset.
  always_comb begin
    mask = '0;
    for (int b = 0; b < NB; b++)
      mask[b] = (b >= int'(off)) && (b < int'(off) + (1 << m_i_size));
  end

  always_ff @(posedge m_clk) begin
    if (accept && m_i_we && !mis) begin
      for (int b = 0; b < NB; b++)
        if (mask[b]) mem[widx][b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end

  always_ff @(posedge m_clk or posedge m_rst) begin
    if (m_rst) begin
      for (int i = 0; i < READ_LAT; i++) st[i] <= '0;
    end else if (!m_i_stall) begin
      st[0].valid   <= m_i_req;
      st[0].mis     <= mis;
      st[0].is_load <= ~m_i_we;
      st[0].size    <= m_i_size;
      st[0].uns     <= m_i_unsigned;
      st[0].off     <= off;
      st[0].data    <= mem[widx];
      for (int i = 1; i < READ_LAT; i++) st[i] <= st[i-1];
    end
  end

  assign fin = st[READ_LAT-1];

  always_comb begin
    sh  = fin.data >> {fin.off, 3'b000};
    w   = DWIDTH;
    sgn = sh[DWIDTH-1];
    case (fin.size)
      2'd0:    begin w = 8;      sgn = sh[7];        end
      2'd1:    begin w = 16;     sgn = sh[15];       end
      2'd2:    begin w = 32;     sgn = sh[31];       end
      default: begin w = DWIDTH; sgn = sh[DWIDTH-1]; end
    endcase
    ext = sh;
    for (int b = 0; b < DWIDTH; b++)
      if (b >= w) ext[b] = ~fin.uns & sgn;
  end

  assign m_o_ack        = fin.valid;
  assign m_o_misaligned = fin.valid & fin.mis;
  assign m_o_load_data  = (fin.valid && fin.is_load && !fin.mis) ? ext : '0;
endmodule
